bcd_conv_arbiter: RTL and testbench

Shares one sequential binary-to-BCD conversion engine between two requesters. It arbitrates round-robin, accepts an 8-bit binary value over a valid/ready handshake, and runs an iterative shift-and-add-3 (double-dabble) conversion over 8 cycles. It returns a 12-bit, three-digit BCD result with the winning requester's ID over a second valid/ready handshake. It sits between producer logic (counters, ADC samples, etc.) and display/formatting logic in the lab datapath.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_conv_arbiter_dd_step.sv | 34 +++
 rtl/bcd_conv_arbiter.sv | 136 +++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion arbiter.
//   state_t : IDLE (arbitrating), SHIFT (conversion running), DONE (result held)
//   BIN_W   : binary operand width
//   BCD_W   : BCD result width (NDIG packed 4-bit digits)
//   NDIG    : number of decimal digits in the result
package bcd_pkg;

  localparam int BIN_W = 8;
  localparam int BCD_W = 12;
  localparam int NDIG  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_conv_arbiter_dd_step.sv
// One combinational double-dabble step: every BCD digit that is 5 or more gets
// +3, then the concatenation {bcd, bin} is shifted left by one bit.
// Ports:
//   bcd_in  : current BCD accumulator (NDIG digits)
//   bin_in  : remaining binary bits, MSB consumed first
//   bcd_out : accumulator after add-3 and shift
//   bin_out : binary bits after shift (LSB filled with 0)
module bcd_dd_step
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  input  logic [BIN_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic [BIN_W-1:0] bin_out
);

  logic [BCD_W-1:0] bcd_adj;

  // A digit of at most 9 plus 3 is at most 12, so the adjust never leaves its
  // nibble and no carry crosses into the next digit.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      logic [3:0] dig;
      assign dig = bcd_in[gi*4 +: 4];
      assign bcd_adj[gi*4 +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
    end
  endgenerate

  // The top accumulator bit is dropped: for 8-bit inputs the hundreds digit
  // never exceeds 2, so bit 11 is always 0 before the shift.
  assign {bcd_out, bin_out} = {bcd_adj[BCD_W-2:0], bin_in, 1'b0};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter in front of a single sequential binary-to-BCD engine.
// An accepted 8-bit operand is converted with one double-dabble step per
// cycle over 8 cycles; the 3-digit BCD result and the owner ID are then held
// until the consumer takes them.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   req0_valid/bin/ready   : requester 0 operand handshake
//   req1_valid/bin/ready   : requester 1 operand handshake
//   rsp_valid/bcd/id/ready : result handshake ([11:8] hundreds .. [3:0] ones)
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int BIN_W = 8,   // fixed at 8 in this revision
  parameter int BCD_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [BIN_W-1:0] req0_bin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [BIN_W-1:0] req1_bin,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [BCD_W-1:0] rsp_bcd,
  output logic             rsp_id,
  input  logic             rsp_ready
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  state_t           state_reg, state_next;
  logic [BIN_W-1:0] bin_reg, bin_next;
  logic [BCD_W-1:0] bcd_reg, bcd_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             id_reg, id_next;
  logic             last_grant_reg, last_grant_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [BCD_W-1:0] rsp_bcd_reg, rsp_bcd_next;
  logic             rsp_id_reg, rsp_id_next;

  logic [BCD_W-1:0] step_bcd;
  logic [BIN_W-1:0] step_bin;
  logic             grant0, grant1;

  bcd_dd_step u_step (
    .bcd_in  (bcd_reg),
    .bin_in  (bin_reg),
    .bcd_out (step_bcd),
    .bin_out (step_bin)
  );

  // Under contention the requester that did not win last time is granted;
  // last_grant_reg == 1 means requester 1 won most recently.
  assign grant0 = (state_reg == IDLE) && req0_valid && (!req1_valid || last_grant_reg);
  assign grant1 = (state_reg == IDLE) && req1_valid && (!req0_valid || !last_grant_reg);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_bcd    = rsp_bcd_reg;
  assign rsp_id     = rsp_id_reg;

  always_comb begin
    state_next      = state_reg;
    bin_next        = bin_reg;
    bcd_next        = bcd_reg;
    cnt_next        = cnt_reg;
    id_next         = id_reg;
    last_grant_next = last_grant_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_bcd_next    = rsp_bcd_reg;
    rsp_id_next     = rsp_id_reg;

    case (state_reg)
      IDLE: begin
        if (grant0 || grant1) begin
          bin_next        = grant1 ? req1_bin : req0_bin;
          bcd_next        = '0;
          cnt_next        = '0;
          id_next         = grant1;
          last_grant_next = grant1;
          state_next      = SHIFT;
        end
      end
      SHIFT: begin
        bcd_next = step_bcd;
        bin_next = step_bin;
        cnt_next = cnt_reg + 1'b1;
        // The final step's output is captured straight into the response
        // register so rsp_valid rises together with a complete result.
        if (cnt_reg == LAST_STEP) begin
          rsp_valid_next = 1'b1;
          rsp_bcd_next   = step_bcd;
          rsp_id_next    = id_reg;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      bin_reg        <= '0;
      bcd_reg        <= '0;
      cnt_reg        <= '0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      rsp_valid_reg  <= 1'b0;
      rsp_bcd_reg    <= '0;
      rsp_id_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bin_reg        <= bin_next;
      bcd_reg        <= bcd_next;
      cnt_reg        <= cnt_next;
      id_reg         <= id_next;
      last_grant_reg <= last_grant_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_bcd_reg    <= rsp_bcd_next;
      rsp_id_reg     <= rsp_id_next;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: scripted scenarios plus a
// randomized sweep, with expected {id, bcd} results queued at acceptance and
// compared when the result handshake happens.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_bin, req1_bin;
  logic        req0_ready, req1_ready;
  logic        rsp_valid;
  logic [11:0] rsp_bcd;
  logic        rsp_id;
  logic        rsp_ready;

  int errors = 0;
  int checks = 0;
  logic [12:0] sb_q[$];   // {id, bcd}
  logic tb_last;          // model of last grant (1 = requester 1)
  logic tb_busy;          // model: conversion in flight or result held

  always #5 clk = ~clk;

  bcd_conv_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_bin   (req0_bin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_bin   (req1_bin),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_bcd    (rsp_bcd),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready)
  );

  // Reference: decimal digits by division, independent of double-dabble.
  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_bin = 8'd0; req1_bin = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_bcd !== 12'h000 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b bcd=%h id=%b, expected 0/000/0", rsp_valid, rsp_bcd, rsp_id);
    end
    // Both valid while held in reset: last_grant=1 makes requester 0 win.
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_last_grant: got ready0=%b ready1=%b, expected 1/0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    tb_last = 1'b1; tb_busy = 1'b0;
    sb_q.delete();
    $display("test_reset done");
  endtask

  task automatic test_zero_latency();
    int n;
    logic [12:0] exp;
    @(negedge clk);
    req0_valid = 1'b1; req0_bin = 8'd0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_accept: got ready0=%b, expected 1", req0_ready);
    end
    sb_q.push_back({1'b0, ref_bcd(0)});
    @(posedge clk);
    #1 req0_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (rsp_valid) break;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles, expected 8", n);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({rsp_id, rsp_bcd} !== exp) begin
      errors++;
      $display("FAIL zero_rsp: got id=%b bcd=%h, expected id=%b bcd=%h", rsp_id, rsp_bcd, exp[12], exp[11:0]);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_rsp_drop: got rsp_valid=%b, expected 0", rsp_valid);
    end
    tb_last = 1'b0;
    $display("test_zero_latency: id=%b bcd=%h cycles=%0d", exp[12], exp[11:0], n);
  endtask

  task automatic test_req1_max();
    int n;
    logic [12:0] exp;
    @(negedge clk);
    req1_valid = 1'b1; req1_bin = 8'd255;
    #1;
    if (req1_ready) sb_q.push_back({1'b1, ref_bcd(255)});
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL max_accept: got ready0=%b ready1=%b, expected 0/1", req0_ready, req1_ready);
    end
    @(negedge clk); req1_valid = 1'b0;
    n = 0;
    while (n < 20 && !rsp_valid) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL max_ready0: got %b, expected 0", req0_ready);
      end
      @(negedge clk); n++;
    end
    checks++;
    if (!rsp_valid || sb_q.size() == 0) begin
      errors++;
      $display("FAIL max_timeout: got rsp_valid=%b queued=%0d, expected response", rsp_valid, sb_q.size());
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if ({rsp_id, rsp_bcd} !== exp) begin
        errors++;
        $display("FAIL max_rsp: got id=%b bcd=%h, expected id=%b bcd=%h", rsp_id, rsp_bcd, exp[12], exp[11:0]);
      end
      $display("test_req1_max: id=%b bcd=%h", rsp_id, rsp_bcd);
    end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    tb_last = 1'b1;
  endtask

  task automatic test_alternate();
    logic exp_ids [3] = '{1'b0, 1'b1, 1'b0};
    logic [12:0] exp;
    int got = 0;
    int cyc = 0;
    rsp_ready = 1'b1; req0_bin = 8'd37; req1_bin = 8'd99;
    while (got < 3 && cyc < 200) begin
      @(negedge clk); cyc++;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      if (req0_ready) sb_q.push_back({1'b0, ref_bcd(37)});
      if (req1_ready) sb_q.push_back({1'b1, ref_bcd(99)});
      if (rsp_valid && rsp_ready) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 13'h1fff;
        checks++;
        if ({rsp_id, rsp_bcd} !== exp || rsp_id !== exp_ids[got]) begin
          errors++;
          $display("FAIL alt_rsp%0d: got id=%b bcd=%h, expected id=%b bcd=%h", got, rsp_id, rsp_bcd, exp_ids[got], exp[11:0]);
        end
        $display("test_alternate rsp%0d: id=%b bcd=%h", got, rsp_id, rsp_bcd);
        got++;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL alt_timeout: got %0d responses, expected 3", got);
    end
    tb_last = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    logic [12:0] exp;
    @(negedge clk);
    req0_valid = 1'b1; req0_bin = 8'd123;
    #1;
    if (req0_ready) sb_q.push_back({1'b0, ref_bcd(123)});
    @(negedge clk); req0_valid = 1'b0;
    req1_valid = 1'b1; req1_bin = 8'd99;
    n = 0;
    while (n < 20 && !rsp_valid) begin
      @(negedge clk); n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_bcd !== 12'h123 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b bcd=%h r0=%b r1=%b, expected 1/123/0/0", i, rsp_valid, rsp_bcd, req0_ready, req1_ready);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_early_accept: got ready1=%b, expected 0", req1_ready);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 13'h1fff;
    checks++;
    if ({rsp_id, rsp_bcd} !== exp || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_rsp: got valid=%b id=%b bcd=%h, expected 1 id=%b bcd=%h", rsp_valid, rsp_id, rsp_bcd, exp[12], exp[11:0]);
    end
    $display("test_stall rsp: id=%b bcd=%h", rsp_id, rsp_bcd);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_next_accept: got ready1=%b rsp_valid=%b, expected 1/0", req1_ready, rsp_valid);
    end
    if (req1_ready) sb_q.push_back({1'b1, ref_bcd(99)});
    @(negedge clk); req1_valid = 1'b0;
    n = 0;
    while (n < 20 && !rsp_valid) begin
      @(negedge clk); n++;
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 13'h1fff;
    checks++;
    if ({rsp_id, rsp_bcd} !== exp || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_pending_rsp: got valid=%b id=%b bcd=%h, expected 1 id=%b bcd=%h", rsp_valid, rsp_id, rsp_bcd, exp[12], exp[11:0]);
    end
    $display("test_stall pending rsp: id=%b bcd=%h", rsp_id, rsp_bcd);
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    tb_last = 1'b1;
  endtask

  task automatic test_reset_abort();
    logic exp_ids [2] = '{1'b0, 1'b1};
    logic [12:0] exp;
    int got = 0;
    int cyc = 0;
    @(negedge clk);
    req1_valid = 1'b1; req1_bin = 8'd200;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_accept: got ready1=%b, expected 1", req1_ready);
    end
    @(negedge clk); req1_valid = 1'b0;   // just after acceptance edge k
    repeat (3) @(negedge clk);
    rst_n = 1'b0;                         // sampled at edge k+4 (step 4)
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_rsp%0d: got rsp_valid=%b, expected 0", i, rsp_valid);
      end
      @(negedge clk);
    end
    sb_q.delete();
    tb_last = 1'b1;
    rsp_ready = 1'b1; req0_bin = 8'd12; req1_bin = 8'd77;
    while (got < 2 && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      req0_valid = (got == 0); req1_valid = 1'b1;
      #1;
      if (req0_valid && req0_ready) sb_q.push_back({1'b0, ref_bcd(12)});
      if (req1_valid && req1_ready) sb_q.push_back({1'b1, ref_bcd(77)});
      if (rsp_valid && rsp_ready) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 13'h1fff;
        checks++;
        if ({rsp_id, rsp_bcd} !== exp || rsp_id !== exp_ids[got]) begin
          errors++;
          $display("FAIL abort_after_rsp%0d: got id=%b bcd=%h, expected id=%b bcd=%h", got, rsp_id, rsp_bcd, exp_ids[got], exp[11:0]);
        end
        $display("test_reset_abort rsp%0d: id=%b bcd=%h", got, rsp_id, rsp_bcd);
        got++;
        if (got == 1) req0_valid = 1'b0;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL abort_timeout: got %0d responses, expected 2", got);
    end
    tb_last = 1'b1; tb_busy = 1'b0;
  endtask

  task automatic test_random_sweep();
    int idx0 = 0, idx1 = 0, got = 0, cyc = 0;
    logic drop0 = 1'b0, drop1 = 1'b0;
    logic e0, e1;
    logic [12:0] exp;
    sb_q.delete();
    tb_busy = 1'b0;
    while (got < 512 && cyc < 30000) begin
      @(negedge clk); cyc++;
      if (drop0) begin req0_valid = 1'b0; drop0 = 1'b0; end
      if (drop1) begin req1_valid = 1'b0; drop1 = 1'b0; end
      if (!req0_valid && idx0 < 256 && $urandom_range(3) != 0) begin
        req0_valid = 1'b1; req0_bin = 8'(idx0); idx0++;
      end
      if (!req1_valid && idx1 < 256 && $urandom_range(3) != 0) begin
        req1_valid = 1'b1; req1_bin = 8'(255 - idx1); idx1++;
      end
      rsp_ready = ($urandom_range(2) != 0);
      #1;
      e0 = !tb_busy && req0_valid && (!req1_valid || tb_last);
      e1 = !tb_busy && req1_valid && (!req0_valid || !tb_last);
      checks++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        errors++;
        $display("FAIL rand_ready c%0d: got r0=%b r1=%b, expected r0=%b r1=%b", cyc, req0_ready, req1_ready, e0, e1);
      end
      if (req0_valid && req0_ready) begin
        sb_q.push_back({1'b0, ref_bcd(int'(req0_bin))});
        tb_last = 1'b0; tb_busy = 1'b1; drop0 = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back({1'b1, ref_bcd(int'(req1_bin))});
        tb_last = 1'b1; tb_busy = 1'b1; drop1 = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 13'h1fff;
        checks++;
        if ({rsp_id, rsp_bcd} !== exp) begin
          errors++;
          $display("FAIL rand_rsp%0d: got id=%b bcd=%h, expected id=%b bcd=%h", got, rsp_id, rsp_bcd, exp[12], exp[11:0]);
        end
        got++;
        tb_busy = 1'b0;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (got != 512) begin
      errors++;
      $display("FAIL rand_timeout: got %0d responses, expected 512", got);
    end
    $display("test_random_sweep: %0d responses in %0d cycles", got, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_bin = 8'd0; req1_bin = 8'd0;
    rsp_ready = 1'b0;
    tb_last = 1'b1; tb_busy = 1'b0;
    test_reset();
    test_zero_latency();
    test_req1_max();
    test_alternate();
    test_stall();
    test_reset_abort();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
